pc_ras_unit: RTL and testbench
==============================

// Module: pc_ras_unit
// PURPOSE
//  Parametrised program-counter register with next-PC selection and a return-address stack (RAS).
//  Sits at the head of the IF stage; its output addresses instruction memory.
//  Next PC source, in priority order: trap vector, EX-stage redirect, stall hold, RAS-predicted return, sequential increment.
//  Supersedes the plain enable-gated PC register.
// PARAMETERS
//  XLEN       32            PC width in bits
//  RESET_VEC  32'h0000_0000 PC value on reset
//  TRAP_VEC   32'h0000_0100 PC loaded on trap_valid
//  INC        4             sequential increment (bytes per instruction)
//  RAS_DEPTH  4             RAS entries; power of two, >=2
// PORTS
//  clk            in   1        clock; rising edge
//  rst            in   1        asynchronous, active-low reset (rst=0 resets)
//  pc_en          in   1        1 = advance PC; 0 = stall (hold PC)
//  redirect_valid in   1        EX-stage branch/jump resolved taken or mispredicted
//  redirect_addr  in   XLEN     target for redirect_valid
//  trap_valid     in   1        exception/interrupt entry
//  call_push      in   1        current fetched instr is a call; push pc+INC
//  ret_pop        in   1        current fetched instr is a return; predict RAS top
//  ras_flush      in   1        clear RAS (count=0); no effect on PC
//  pc             out  XLEN     current PC (registered)
//  pc_plus        out  XLEN     pc+INC (combinational, mod 2^XLEN)
//  ras_empty      out  1        count==0
//  ras_full       out  1        count==RAS_DEPTH
// BEHAVIOUR
//  - Reset (rst=0, async): pc=RESET_VEC, RAS count=0, top pointer=0, ras_empty=1, ras_full=0. Entries need not be cleared.
//  - PC update: one cycle latency; the next-PC choice made in cycle N appears on pc after edge N+1.
//    - trap_valid: pc<=TRAP_VEC; RAS cleared. Applies regardless of pc_en.
//    - else redirect_valid: pc<=redirect_addr. Applies regardless of pc_en. RAS unchanged.
//    - else pc_en=0: pc held; call_push/ret_pop ignored.
//    - else ret_pop & !ras_empty: pc<=RAS top; count-1.
//    - else: pc<=pc+INC. Covers ret_pop on empty: no pop, count stays 0.
//  - call_push is honoured only in the pc_en=1, no-trap, no-redirect case; it pushes pc+INC.
//    It is independent of the PC choice (a call's own target arrives later via redirect).
//  - Simultaneous ret_pop & call_push (non-empty): pop target is used for the PC; pushed value overwrites the popped slot; count unchanged.
//  - Push when full: circular overwrite of the oldest entry; top pointer advances mod RAS_DEPTH; count saturates at RAS_DEPTH.
//  - Pop after overwrite returns at most RAS_DEPTH most-recent values, newest first.
//  - ras_flush: count<=0 at next edge. It is lower priority than push in the same cycle (flush then push gives count=1).
//  - Arithmetic: pointer is log2(RAS_DEPTH) bits and wraps naturally. pc+INC wraps mod 2^XLEN; no overflow flag.
//  - No X propagation: pc never takes an unreset value; RAS contents are read only when count>0.
// STRUCTURE
//  - Shared package cpu_pkg: XLEN, RESET_VEC, TRAP_VEC, INC defaults; a next-PC select enum (SEL_TRAP, SEL_REDIR, SEL_HOLD, SEL_RAS, SEL_SEQ).
//  - One sub-module, ras_stack: circular buffer with push/pop/flush, top/empty/full outputs, parametrised by XLEN and RAS_DEPTH.
//  - Top level: priority select (combinational) plus PC register.
// TESTING
//  1. Hold rst=0 for 3 cycles, release; pc_en=1 -> pc=0x0 during reset, then 0x4, 0x8, 0xC on successive edges; ras_empty=1.
//  2. pc_en=0 for 2 cycles at pc=0x10 -> pc stays 0x10; pc_en=0 with redirect_valid, addr=0x200 -> pc=0x200 next edge.
//  3. call_push at pc=0x20, redirect to 0x300, then ret_pop at 0x304 -> pc=0x24; ras_empty=1 afterwards.
//  4. RAS_DEPTH=4: 5 pushes at pcs 0x0,0x10,0x20,0x30,0x40 -> ras_full=1; 4 pops yield 0x44,0x34,0x24,0x14; 5th pop -> sequential pc+4.
//  5. trap_valid with redirect_valid, call_push and pc_en=0 all asserted -> pc=TRAP_VEC (0x100); ras_empty=1.
//  6. Mid-sequence async reset (rst low between edges) -> pc=0x0 immediately, RAS empty; ret_pop next cycle -> pc=0x4.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default PC parameters and the next-PC source select.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int          DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
  localparam int          DEF_INC       = 4;
  localparam int          DEF_RAS_DEPTH = 4;

  // Next-PC sources, listed highest priority first.
  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_REDIR,
    SEL_HOLD,
    SEL_RAS,
    SEL_SEQ
  } next_pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with push/pop/flush; the oldest entry is overwritten when full.
// Latency: push/pop/flush take effect at the next clock edge; o_top_dat is combinational from state.
// Backpressure: none; a push when full overwrites, and a pop when empty is ignored.
// Ports: clk, i_rst_n (async low); i_push/i_push_dat, i_pop, i_flush; o_top_dat, o_empty, o_full.
module ras_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_push_dat,
  output logic [XLEN-1:0] o_top_dat,
  output logic            o_empty,
  output logic            o_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_count;

  logic            w_pop_ok;
  logic [PW-1:0]   w_top_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [PW-1:0]   w_wr_idx;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(RAS_DEPTH));
  assign o_top_dat = r_mem[r_top];
  assign w_pop_ok  = i_pop && !o_empty;

  // Push together with pop replaces the top entry in place; otherwise a
  // push goes to the slot above the top, which is the oldest slot when full.
  assign w_wr_idx  = w_pop_ok ? r_top : (r_top + PW'(1));

  always_comb begin
    w_top_nxt   = r_top;
    w_count_nxt = r_count;
    if (i_push && w_pop_ok) begin
      w_top_nxt   = r_top;
      w_count_nxt = r_count;
    end else if (i_push) begin
      w_top_nxt = r_top + PW'(1);
      if (!o_full) begin
        w_count_nxt = r_count + CW'(1);
      end
    end else if (w_pop_ok) begin
      w_top_nxt   = r_top - PW'(1);
      w_count_nxt = r_count - CW'(1);
    end
    // Flush acts first and a same-cycle push lands on top of the empty stack.
    if (i_flush) begin
      w_count_nxt = i_push ? CW'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_top   <= '0;
      r_count <= '0;
    end else begin
      r_top   <= w_top_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Entries are not reset; they are read only when the count is non-zero.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[w_wr_idx] <= i_push_dat;
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage PC register with prioritised next-PC select (trap, redirect, hold, RAS return, sequential).
// Latency: the next-PC choice made in cycle N is visible on pc after the following edge; pc_plus is combinational.
// Backpressure: pc_en=0 holds the PC and suppresses RAS push/pop; trap and redirect still apply.
// Ports: clk, rst (async low); pc_en, redirect_valid/addr, trap_valid, call_push, ret_pop, ras_flush;
//        pc, pc_plus, ras_empty, ras_full.
module pc_ras_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              INC       = DEF_INC,
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            trap_valid,
  input  logic            call_push,
  input  logic            ret_pop,
  input  logic            ras_flush,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            ras_empty,
  output logic            ras_full
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  next_pc_sel_e    w_sel;

  assign w_pc_plus = r_pc + XLEN'(INC);

  always_comb begin
    w_sel = SEL_SEQ;
    if (trap_valid) begin
      w_sel = SEL_TRAP;
    end else if (redirect_valid) begin
      w_sel = SEL_REDIR;
    end else if (!pc_en) begin
      w_sel = SEL_HOLD;
    end else if (ret_pop && !w_ras_empty) begin
      w_sel = SEL_RAS;
    end
  end

  always_comb begin
    w_pc_nxt = w_pc_plus;
    case (w_sel)
      SEL_TRAP:  w_pc_nxt = TRAP_VEC;
      SEL_REDIR: w_pc_nxt = redirect_addr;
      SEL_HOLD:  w_pc_nxt = r_pc;
      SEL_RAS:   w_pc_nxt = w_ras_top;
      default:   w_pc_nxt = w_pc_plus;
    endcase
  end

  // A call pushes only when the fetch actually advances; its own target
  // arrives later through the redirect path, so the push does not steer the PC.
  assign w_push  = call_push && pc_en && !trap_valid && !redirect_valid;
  assign w_pop   = (w_sel == SEL_RAS);
  assign w_flush = ras_flush || trap_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_VEC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .i_rst_n    (rst),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .i_push_dat (w_pc_plus),
    .o_top_dat  (w_ras_top),
    .o_empty    (w_ras_empty),
    .o_full     (w_ras_full)
  );

  assign pc        = r_pc;
  assign pc_plus   = w_pc_plus;
  assign ras_empty = w_ras_empty;
  assign ras_full  = w_ras_full;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Testbench for pc_ras_unit: directed scenarios plus randomized traffic against a queue-based model.
// Latency: expected state is queued before each rising edge and compared just after it.
// Backpressure: n/a.
module tb_pc_ras_unit;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        trap_valid;
  logic        call_push;
  logic        ret_pop;
  logic        ras_flush;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic        ras_empty;
  logic        ras_full;

  pc_ras_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_en          (pc_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .trap_valid     (trap_valid),
    .call_push      (call_push),
    .ret_pop        (ret_pop),
    .ras_flush      (ras_flush),
    .pc             (pc),
    .pc_plus        (pc_plus),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_ras[$];   // newest entry at the back
  logic [31:0] m_pc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: apply one cycle of inputs, then queue the expected outputs.
  task automatic step(input logic en, input logic rd, input logic [31:0] ad,
                      input logic tr, input logic cp, input logic rp, input logic fl);
    logic [31:0] nxt;
    exp_t        e;
    pc_en = en; redirect_valid = rd; redirect_addr = ad;
    trap_valid = tr; call_push = cp; ret_pop = rp; ras_flush = fl;
    if (!rst) begin
      m_pc = 32'h0;
      m_ras.delete();
    end else if (tr) begin
      m_pc = 32'h100;
      m_ras.delete();
    end else begin
      nxt = m_pc;
      if (rd) begin
        nxt = ad;
      end else if (en) begin
        if (rp && m_ras.size() > 0) nxt = m_ras.pop_back();
        else                        nxt = m_pc + 32'd4;
      end
      if (fl) m_ras.delete();
      if (!rd && en && cp) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      m_pc = nxt;
    end
    e.pc    = m_pc;
    e.plus  = m_pc + 32'd4;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == 4);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare the oldest queued expectation just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_pc_plus", pc_plus, e.plus);
        chk("sb_ras_empty", {31'b0, ras_empty}, {31'b0, e.empty});
        chk("sb_ras_full", {31'b0, ras_full}, {31'b0, e.full});
      end
    end
  end

  logic [31:0] pops [4];

  initial begin
    rst = 1'b0;
    pc_en = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    trap_valid = 1'b0; call_push = 1'b0; ret_pop = 1'b0; ras_flush = 1'b0;
    m_pc = 32'h0;
    pops[0] = 32'h44; pops[1] = 32'h34; pops[2] = 32'h24; pops[3] = 32'h14;

    // 1: reset held for three cycles, then sequential fetch
    idle(3);
    chk("reset_pc", pc, 32'h0);
    chk("reset_empty", {31'b0, ras_empty}, 32'h1);
    chk("reset_full", {31'b0, ras_full}, 32'h0);
    rst = 1'b1;
    idle(3);
    chk("seq_pc_c", pc, 32'hC);
    chk("seq_empty", {31'b0, ras_empty}, 32'h1);

    // 2: stall hold, then redirect during stall
    idle(1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_hold", pc, 32'h10);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_redirect", pc, 32'h200);

    // 3: call, jump to callee, return
    step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("callee_pc", pc, 32'h304);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("return_pc", pc, 32'h24);
    chk("return_empty", {31'b0, ras_empty}, 32'h1);

    // 4: five pushes into a four-deep stack, then drain past empty
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b1, 32'(k * 16), 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("overflow_full", {31'b0, ras_full}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("pop_order", pc, pops[k]);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop_empty_seq", pc, 32'h18);

    // 5: trap beats everything and clears the stack
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("trap_pc", pc, 32'h100);
    chk("trap_empty", {31'b0, ras_empty}, 32'h1);

    // 6: asynchronous reset between edges
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_empty", {31'b0, ras_empty}, 32'h1);
    m_pc = 32'h0;
    m_ras.delete();
    #1;
    rst = 1'b1;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_pop", pc, 32'h4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(127) != 0);
      step($urandom_range(7) != 0,
           $urandom_range(7) == 0,
           $urandom & 32'hFFFF_FFFC,
           $urandom_range(31) == 0,
           $urandom_range(3) == 0,
           $urandom_range(2) == 0,
           $urandom_range(15) == 0);
    end
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
